// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, funct encodings, mul/div op codes and sequencer states
// for the multicycle MIPS ALU control unit.
package alu_ctrl_pkg;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU = 4'b1000;
    localparam logic [3:0] CTRL_NOR  = 4'b1001;
    localparam logic [3:0] CTRL_SLL  = 4'b1010;
    localparam logic [3:0] CTRL_SRL  = 4'b1011;
    localparam logic [3:0] CTRL_SRA  = 4'b1100;
    localparam logic [3:0] CTRL_MD   = 4'b1101;
    localparam logic [3:0] CTRL_NOP  = 4'b1111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MD_INIT,
        MD_RUN,
        MD_DONE
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational decode of ALUOp + funct into an ALU control code, a mul/div flag,
// the mul/div op and an illegal flag.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int CTRL_W  = 4
) (
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [5:0]         funct,
    output logic [CTRL_W-1:0]  code,
    output logic               is_md,
    output logic               illegal,
    output logic [1:0]         md_op
);

    logic [3:0] fn_code;
    logic       fn_md;
    logic [3:0] code4;

    always_comb begin
        fn_code = CTRL_NOP;
        fn_md   = 1'b0;
        md_op   = MD_MULT;
        case (funct)
            FN_ADD, FN_ADDU: fn_code = CTRL_ADD;
            FN_SUB, FN_SUBU: fn_code = CTRL_SUB;
            FN_AND:          fn_code = CTRL_AND;
            FN_OR:           fn_code = CTRL_OR;
            FN_XOR:          fn_code = CTRL_XOR;
            FN_NOR:          fn_code = CTRL_NOR;
            FN_SLT:          fn_code = CTRL_SLT;
            FN_SLTU:         fn_code = CTRL_SLTU;
            FN_SLL:          fn_code = CTRL_SLL;
            FN_SRL:          fn_code = CTRL_SRL;
            FN_SRA:          fn_code = CTRL_SRA;
            FN_MULT:  begin fn_code = CTRL_MD; fn_md = 1'b1; md_op = MD_MULT;  end
            FN_MULTU: begin fn_code = CTRL_MD; fn_md = 1'b1; md_op = MD_MULTU; end
            FN_DIV:   begin fn_code = CTRL_MD; fn_md = 1'b1; md_op = MD_DIV;   end
            FN_DIVU:  begin fn_code = CTRL_MD; fn_md = 1'b1; md_op = MD_DIVU;  end
            default:         fn_code = CTRL_NOP;
        endcase
    end

    // ALUOp codes beyond the four defined ones fall through to NOP and are flagged illegal.
    always_comb begin
        code4 = CTRL_NOP;
        is_md = 1'b0;
        case (alu_op)
            ALUOP_W'(ALUOP_ADD):   code4 = CTRL_ADD;
            ALUOP_W'(ALUOP_SUB):   code4 = CTRL_SUB;
            ALUOP_W'(ALUOP_SLT):   code4 = CTRL_SLT;
            ALUOP_W'(ALUOP_RTYPE): begin
                code4 = fn_code;
                is_md = fn_md;
            end
            default:               code4 = CTRL_NOP;
        endcase
    end

    assign illegal = (code4 == CTRL_NOP);
    assign code    = CTRL_W'(code4);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit with an iterative mult/div sequencer.
// Define MD_EARLY_TERM_EN to let md_early_i end the mult/div run early.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int CTRL_W  = 4,
    parameter int MD_ITER = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [5:0]         funct_i,
    input  logic               flush_i,
    input  logic               md_early_i,
    output logic [CTRL_W-1:0]  alu_ctrl_o,
    output logic               ctrl_valid_o,
    output logic               illegal_o,
    output logic [1:0]         md_op_o,
    output logic               md_init_o,
    output logic               md_step_o,
    output logic               md_done_o,
    output logic               hilo_we_o,
    output logic               md_busy_o
);

    localparam int               CNT_W    = $clog2(MD_ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CTRL_W-1:0]  dec_code, ctrl_nxt;
    logic               dec_md, dec_illegal;
    logic [1:0]         dec_md_op, md_op_nxt;
    logic               ctrl_valid_nxt, illegal_nxt, init_nxt, step_nxt, done_nxt;
    logic               last_step;

    alu_funct_decode #(
        .ALUOP_W (ALUOP_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .alu_op  (alu_op_i),
        .funct   (funct_i),
        .code    (dec_code),
        .is_md   (dec_md),
        .illegal (dec_illegal),
        .md_op   (dec_md_op)
    );

`ifdef MD_EARLY_TERM_EN
    assign last_step = (cnt == CNT_LAST) || md_early_i;
`else
    logic unused_md_early;
    assign unused_md_early = md_early_i;
    assign last_step       = (cnt == CNT_LAST);
`endif

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ctrl_nxt       = alu_ctrl_o;
        md_op_nxt      = md_op_o;
        ctrl_valid_nxt = 1'b0;
        illegal_nxt    = 1'b0;
        init_nxt       = 1'b0;
        step_nxt       = 1'b0;
        done_nxt       = 1'b0;
        if (flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        ctrl_valid_nxt = 1'b1;
                        ctrl_nxt       = dec_code;
                        illegal_nxt    = dec_illegal;
                        if (dec_md) begin
                            md_op_nxt = dec_md_op;
                            init_nxt  = 1'b1;
                            state_nxt = MD_INIT;
                        end
                    end
                end
                MD_INIT: begin
                    cnt_nxt   = '0;
                    step_nxt  = 1'b1;
                    state_nxt = MD_RUN;
                end
                MD_RUN: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (last_step) begin
                        done_nxt  = 1'b1;
                        state_nxt = MD_DONE;
                    end else begin
                        step_nxt = 1'b1;
                    end
                end
                MD_DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            alu_ctrl_o   <= CTRL_W'(CTRL_NOP);
            ctrl_valid_o <= 1'b0;
            illegal_o    <= 1'b0;
            md_op_o      <= 2'b00;
            md_init_o    <= 1'b0;
            md_step_o    <= 1'b0;
            md_done_o    <= 1'b0;
            hilo_we_o    <= 1'b0;
            md_busy_o    <= 1'b0;
            ready_o      <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            alu_ctrl_o   <= ctrl_nxt;
            ctrl_valid_o <= ctrl_valid_nxt;
            illegal_o    <= illegal_nxt;
            md_op_o      <= md_op_nxt;
            md_init_o    <= init_nxt;
            md_step_o    <= step_nxt;
            md_done_o    <= done_nxt;
            hilo_we_o    <= done_nxt;
            md_busy_o    <= (state_nxt != IDLE);
            ready_o      <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed, table-driven bench for alu_ctrl_seq: decode vectors plus hand-written
// mult/div, flush, early-termination and reset sequences.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] alu_op_i;
    logic [5:0] funct_i;
    logic       flush_i;
    logic       md_early_i;
    logic [3:0] alu_ctrl_o;
    logic       ctrl_valid_o;
    logic       illegal_o;
    logic [1:0] md_op_o;
    logic       md_init_o;
    logic       md_step_o;
    logic       md_done_o;
    logic       hilo_we_o;
    logic       md_busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] code;
        logic       ill;
        string      name;
    } vec_t;

    vec_t vecs[$];

    alu_ctrl_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .alu_op_i     (alu_op_i),
        .funct_i      (funct_i),
        .flush_i      (flush_i),
        .md_early_i   (md_early_i),
        .alu_ctrl_o   (alu_ctrl_o),
        .ctrl_valid_o (ctrl_valid_o),
        .illegal_o    (illegal_o),
        .md_op_o      (md_op_o),
        .md_init_o    (md_init_o),
        .md_step_o    (md_step_o),
        .md_done_o    (md_done_o),
        .hilo_we_o    (hilo_we_o),
        .md_busy_o    (md_busy_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn,
                                 input logic fl, input logic early);
        valid_i    = v;
        alu_op_i   = op;
        funct_i    = fn;
        flush_i    = fl;
        md_early_i = early;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_ready"}, ready_o, 1);
        checkOutput({name, "_busy"}, md_busy_o, 0);
        checkOutput({name, "_step"}, md_step_o, 0);
        checkOutput({name, "_done"}, md_done_o, 0);
        checkOutput({name, "_we"}, hilo_we_o, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  steps;
        bit  seen_done;
        int  exp_steps;

        vecs.push_back('{2'b00, 6'b111111, 4'b0010, 1'b0, "aluop_add"});
        vecs.push_back('{2'b01, 6'b000000, 4'b0110, 1'b0, "aluop_sub"});
        vecs.push_back('{2'b11, 6'b100000, 4'b0111, 1'b0, "aluop_slt"});
        vecs.push_back('{2'b10, 6'b100010, 4'b0110, 1'b0, "fn_sub"});
        vecs.push_back('{2'b10, 6'b101010, 4'b0111, 1'b0, "fn_slt"});
        vecs.push_back('{2'b10, 6'b100000, 4'b0010, 1'b0, "fn_add"});
        vecs.push_back('{2'b10, 6'b100001, 4'b0010, 1'b0, "fn_addu"});
        vecs.push_back('{2'b10, 6'b100011, 4'b0110, 1'b0, "fn_subu"});
        vecs.push_back('{2'b10, 6'b100100, 4'b0000, 1'b0, "fn_and"});
        vecs.push_back('{2'b10, 6'b100101, 4'b0001, 1'b0, "fn_or"});
        vecs.push_back('{2'b10, 6'b100110, 4'b0011, 1'b0, "fn_xor"});
        vecs.push_back('{2'b10, 6'b100111, 4'b1001, 1'b0, "fn_nor"});
        vecs.push_back('{2'b10, 6'b101011, 4'b1000, 1'b0, "fn_sltu"});
        vecs.push_back('{2'b10, 6'b000000, 4'b1010, 1'b0, "fn_sll"});
        vecs.push_back('{2'b10, 6'b000010, 4'b1011, 1'b0, "fn_srl"});
        vecs.push_back('{2'b10, 6'b000011, 4'b1100, 1'b0, "fn_sra"});
        vecs.push_back('{2'b10, 6'b111111, 4'b1111, 1'b1, "fn_ill_3f"});
        vecs.push_back('{2'b10, 6'b001000, 4'b1111, 1'b1, "fn_ill_08"});
        vecs.push_back('{2'b10, 6'b000001, 4'b1111, 1'b1, "fn_ill_01"});

        // Reset state
        rst_n = 1'b0;
        applyStimulus(0, 2'b00, 6'b000000, 0, 0);
        @(negedge clk);
        checkOutput("rst_ctrl", alu_ctrl_o, 4'b1111);
        checkOutput("rst_ctrl_valid", ctrl_valid_o, 0);
        checkOutput("rst_illegal", illegal_o, 0);
        checkOutput("rst_init", md_init_o, 0);
        checkIdle("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back decode vectors, one accepted per cycle
        foreach (vecs[i]) begin
            applyStimulus(1, vecs[i].op, vecs[i].fn, 0, 0);
            tick();
            checkOutput({vecs[i].name, "_valid"}, ctrl_valid_o, 1);
            checkOutput({vecs[i].name, "_code"}, alu_ctrl_o, vecs[i].code);
            checkOutput({vecs[i].name, "_illegal"}, illegal_o, vecs[i].ill);
            checkOutput({vecs[i].name, "_ready"}, ready_o, 1);
            checkOutput({vecs[i].name, "_busy"}, md_busy_o, 0);
        end
        applyStimulus(0, 2'b00, 6'b000000, 0, 0);
        tick();
        checkOutput("idle_no_valid", ctrl_valid_o, 0);
        checkOutput("idle_no_illegal", illegal_o, 0);

        // flush with a request in IDLE drops it
        applyStimulus(1, 2'b10, 6'b100000, 1, 0);
        tick();
        checkOutput("flush_idle_valid", ctrl_valid_o, 0);
        checkIdle("flush_idle");
        applyStimulus(0, 2'b00, 6'b000000, 0, 0);

        // DIV: full 32-step sequence while a new request is held and ignored
        applyStimulus(1, 2'b10, 6'b011010, 0, 0);
        tick();
        checkOutput("div_valid", ctrl_valid_o, 1);
        checkOutput("div_code", alu_ctrl_o, 4'b1101);
        checkOutput("div_illegal", illegal_o, 0);
        checkOutput("div_md_op", md_op_o, 2'b10);
        checkOutput("div_init", md_init_o, 1);
        checkOutput("div_ready", ready_o, 0);
        checkOutput("div_busy", md_busy_o, 1);
        applyStimulus(1, 2'b10, 6'b100000, 0, 0);
        for (int i = 0; i < 32; i++) begin
            tick();
            checkOutput($sformatf("div_step%0d", i), md_step_o, 1);
            checkOutput($sformatf("div_step%0d_done", i), md_done_o, 0);
            checkOutput($sformatf("div_step%0d_cv", i), ctrl_valid_o, 0);
            checkOutput($sformatf("div_step%0d_ready", i), ready_o, 0);
            checkOutput($sformatf("div_step%0d_init", i), md_init_o, 0);
        end
        tick();
        checkOutput("div_done", md_done_o, 1);
        checkOutput("div_we", hilo_we_o, 1);
        checkOutput("div_done_step", md_step_o, 0);
        checkOutput("div_done_ready", ready_o, 0);
        checkOutput("div_done_busy", md_busy_o, 1);
        checkOutput("div_done_md_op", md_op_o, 2'b10);
        applyStimulus(0, 2'b00, 6'b000000, 0, 0);
        tick();
        checkOutput("div_after_cv", ctrl_valid_o, 0);
        checkIdle("div_after");

        // MULTU flushed on its 10th step
        applyStimulus(1, 2'b10, 6'b011001, 0, 0);
        tick();
        checkOutput("multu_md_op", md_op_o, 2'b01);
        checkOutput("multu_init", md_init_o, 1);
        applyStimulus(0, 2'b00, 6'b000000, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checkOutput($sformatf("multu_step%0d", i), md_step_o, 1);
        end
        checkOutput("multu_md_op_held", md_op_o, 2'b01);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checkIdle("multu_flush");
        checkOutput("multu_flush_init", md_init_o, 0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done_o || hilo_we_o || md_step_o) seen_done = 1;
        end
        checkOutput("multu_flush_no_done", seen_done, 0);

        // MULT with md_early_i on the 5th step
`ifdef MD_EARLY_TERM_EN
        exp_steps = 5;
`else
        exp_steps = 32;
`endif
        applyStimulus(1, 2'b10, 6'b011000, 0, 0);
        tick();
        checkOutput("mult_md_op", md_op_o, 2'b00);
        checkOutput("mult_init", md_init_o, 1);
        applyStimulus(0, 2'b00, 6'b000000, 0, 0);
        steps = 0;
        seen_done = 0;
        for (int i = 0; i < 60 && !seen_done; i++) begin
            tick();
            if (md_done_o) seen_done = 1;
            if (md_step_o) steps++;
            md_early_i = md_step_o && (steps == 5);
        end
        md_early_i = 1'b0;
        checkOutput("early_done_seen", seen_done, 1);
        checkOutput("early_step_count", steps, exp_steps);
        tick();
        checkIdle("early_after");

        // Asynchronous reset in the middle of a DIV run
        applyStimulus(1, 2'b10, 6'b011011, 0, 0);
        tick();
        checkOutput("rst_mid_busy_before", md_busy_o, 1);
        applyStimulus(0, 2'b00, 6'b000000, 0, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ctrl", alu_ctrl_o, 4'b1111);
        checkOutput("rst_mid_md_op", md_op_o, 0);
        checkOutput("rst_mid_init", md_init_o, 0);
        checkOutput("rst_mid_cv", ctrl_valid_o, 0);
        checkIdle("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkIdle("rst_mid_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
